// File: rtl/rv32_decoder_queue.sv
// rv32_decoder_queue: fetch queue plus registered RV32 decoder with
// valid/ready handshakes on both sides.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_valid/o_ready        : upstream handshake carrying i_inst and i_pc
//   o_valid/i_ready        : downstream handshake for the decoded bundle
//   o_pc .. o_exception    : registered decoded bundle
//   i_flush                : drops queue contents and the output bundle
//   o_count                : queue occupancy
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module rv32_decoder_queue #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned EN_M     = 1,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [31:0]                   i_inst,
   input  logic [31:0]                   i_pc,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [31:0]                   o_pc,
   output logic [4:0]                    o_rs1_addr,
   output logic [4:0]                    o_rs2_addr,
   output logic [4:0]                    o_rd_addr,
   output logic [2:0]                    o_funct3,
   output logic [31:0]                   o_imm,
   output logic [`ALU_WIDTH-1:0]         o_alu,
   output logic [7:0]                    o_muldiv,
   output logic [`OPCODE_WIDTH-1:0]      o_opcode,
   output logic [`EXCEPTION_WIDTH-1:0]   o_exception,
   input  logic                          i_flush,
   output logic [$clog2(DEPTH):0]        o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ALU_W = `ALU_WIDTH;
   localparam int unsigned OPC_W = `OPCODE_WIDTH;
   localparam int unsigned EXC_W = `EXCEPTION_WIDTH;

   // one-hot ALU op indices
   localparam int unsigned ALU_ADD  = 0;
   localparam int unsigned ALU_SUB  = 1;
   localparam int unsigned ALU_SLT  = 2;
   localparam int unsigned ALU_SLTU = 3;
   localparam int unsigned ALU_XOR  = 4;
   localparam int unsigned ALU_OR   = 5;
   localparam int unsigned ALU_AND  = 6;
   localparam int unsigned ALU_SLL  = 7;
   localparam int unsigned ALU_SRL  = 8;
   localparam int unsigned ALU_SRA  = 9;
   localparam int unsigned ALU_EQ   = 10;
   localparam int unsigned ALU_NEQ  = 11;
   localparam int unsigned ALU_GE   = 12;
   localparam int unsigned ALU_GEU  = 13;

   // one-hot opcode class indices
   localparam int unsigned OPC_R      = 0;
   localparam int unsigned OPC_I      = 1;
   localparam int unsigned OPC_LOAD   = 2;
   localparam int unsigned OPC_STORE  = 3;
   localparam int unsigned OPC_BRANCH = 4;
   localparam int unsigned OPC_JAL    = 5;
   localparam int unsigned OPC_JALR   = 6;
   localparam int unsigned OPC_LUI    = 7;
   localparam int unsigned OPC_AUIPC  = 8;
   localparam int unsigned OPC_SYSTEM = 9;
   localparam int unsigned OPC_FENCE  = 10;

   localparam int unsigned EXC_ILLEGAL = 0;
   localparam int unsigned EXC_ECALL   = 1;
   localparam int unsigned EXC_EBREAK  = 2;
   localparam int unsigned EXC_MRET    = 3;

   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // queue storage and control
   logic [31:0]      mem_pc   [DEPTH];
   logic [31:0]      mem_inst [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   assign push    = i_valid && o_ready;
   assign pop     = (count_q != '0) && (!o_valid || i_ready);
   assign o_count = count_q;

   // next occupancy; flush overrides everything
   always_comb begin : count_next
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      if (i_flush) begin
         count_d = '0;
      end
   end

   // pointers, occupancy and registered ready (ready tracks !full one cycle on)
   always_ff @(posedge i_clk or negedge i_rst_n) begin : queue_ctrl
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         o_ready  <= 1'b1;
      end else begin
         count_q <= count_d;
         o_ready <= (count_d != CNT_W'(DEPTH));
         if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // entry storage, no reset needed
   always_ff @(posedge i_clk) begin : queue_mem
      if (push && !i_flush) begin
         mem_pc[wr_ptr_q]   <= i_pc;
         mem_inst[wr_ptr_q] <= i_inst;
      end
   end

   // R/I-type ALU op from funct3; alt selects SUB / SRA
   function automatic logic [ALU_W-1:0] alu_f3(input logic [2:0] f3, input logic alt);
      logic [ALU_W-1:0] r;
      r = '0;
      case (f3)
         3'b000:  r[alt ? ALU_SUB : ALU_ADD] = 1'b1;
         3'b001:  r[ALU_SLL]  = 1'b1;
         3'b010:  r[ALU_SLT]  = 1'b1;
         3'b011:  r[ALU_SLTU] = 1'b1;
         3'b100:  r[ALU_XOR]  = 1'b1;
         3'b101:  r[alt ? ALU_SRA : ALU_SRL] = 1'b1;
         3'b110:  r[ALU_OR]   = 1'b1;
         default: r[ALU_AND]  = 1'b1;
      endcase
      return r;
   endfunction

   // head-of-queue decode
   logic [31:0]      h_inst, h_pc;
   logic [6:0]       h_op, h_f7;
   logic [2:0]       h_f3;
   logic [31:0]      imm_d;
   logic [ALU_W-1:0] alu_d;
   logic [7:0]       md_d;
   logic [OPC_W-1:0] opc_d;
   logic [EXC_W-1:0] exc_d;
   logic             illegal, use_rd, use_rs1, use_rs2;

   assign h_inst = mem_inst[rd_ptr_q];
   assign h_pc   = mem_pc[rd_ptr_q];
   assign h_op   = h_inst[6:0];
   assign h_f3   = h_inst[14:12];
   assign h_f7   = h_inst[31:25];

   always_comb begin : decode_head
      alu_d          = '0;
      alu_d[ALU_ADD] = 1'b1;
      md_d           = '0;
      opc_d          = '0;
      exc_d          = '0;
      imm_d          = '0;
      illegal        = 1'b0;
      use_rd         = 1'b0;
      use_rs1        = 1'b0;
      use_rs2        = 1'b0;
      case (h_op)
         7'b0110011: begin
            opc_d[OPC_R] = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            alu_d   = alu_f3(h_f3, h_inst[30]);
            if (h_f7 == F7_MULDIV) begin
               if (EN_M != 0) begin
                  alu_d        = '0;
                  md_d[h_f3]   = 1'b1;
               end else begin
                  illegal = 1'b1;
               end
            end else if (h_f7 == F7_ALT) begin
               if (h_f3 != 3'b000 && h_f3 != 3'b101) illegal = 1'b1;
            end else if (h_f7 != F7_ZERO) begin
               illegal = 1'b1;
            end
         end
         7'b0010011: begin
            opc_d[OPC_I] = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            // only SRLI/SRAI take inst[30] as the alternate select
            alu_d   = alu_f3(h_f3, (h_f3 == 3'b101) && h_inst[30]);
            imm_d   = {{20{h_inst[31]}}, h_inst[31:20]};
            if ((h_f3 == 3'b001 || h_f3 == 3'b101) && h_inst[25]) illegal = 1'b1;
         end
         7'b0000011: begin
            opc_d[OPC_LOAD] = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            imm_d   = {{20{h_inst[31]}}, h_inst[31:20]};
         end
         7'b0100011: begin
            opc_d[OPC_STORE] = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm_d   = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
         end
         7'b1100011: begin
            opc_d[OPC_BRANCH] = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm_d   = {{19{h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25],
                       h_inst[11:8], 1'b0};
            case (h_f3)
               3'b000:  begin alu_d = '0; alu_d[ALU_EQ]   = 1'b1; end
               3'b001:  begin alu_d = '0; alu_d[ALU_NEQ]  = 1'b1; end
               3'b100:  begin alu_d = '0; alu_d[ALU_SLT]  = 1'b1; end
               3'b101:  begin alu_d = '0; alu_d[ALU_GE]   = 1'b1; end
               3'b110:  begin alu_d = '0; alu_d[ALU_SLTU] = 1'b1; end
               3'b111:  begin alu_d = '0; alu_d[ALU_GEU]  = 1'b1; end
               default: ;
            endcase
         end
         7'b1101111: begin
            opc_d[OPC_JAL] = 1'b1;
            use_rd  = 1'b1;
            imm_d   = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20],
                       h_inst[30:21], 1'b0};
         end
         7'b1100111: begin
            opc_d[OPC_JALR] = 1'b1;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            imm_d   = {{20{h_inst[31]}}, h_inst[31:20]};
         end
         7'b0110111: begin
            opc_d[OPC_LUI] = 1'b1;
            use_rd  = 1'b1;
            imm_d   = {h_inst[31:12], 12'h000};
         end
         7'b0010111: begin
            opc_d[OPC_AUIPC] = 1'b1;
            use_rd  = 1'b1;
            imm_d   = {h_inst[31:12], 12'h000};
         end
         7'b1110011: begin
            opc_d[OPC_SYSTEM] = 1'b1;
            imm_d = {20'h00000, h_inst[31:20]};
            if (h_f3 == 3'b000) begin
               case (h_inst[21:20])
                  2'b00:   exc_d[EXC_ECALL]  = 1'b1;
                  2'b01:   exc_d[EXC_EBREAK] = 1'b1;
                  2'b10:   exc_d[EXC_MRET]   = 1'b1;
                  default: ;
               endcase
            end
         end
         7'b0001111: begin
            opc_d[OPC_FENCE] = 1'b1;
            imm_d = {20'h00000, h_inst[31:20]};
         end
         default: illegal = 1'b1;
      endcase
      // RV32E: only x0..x15 exist
      if (NUM_REGS == 16) begin
         if ((use_rd  && h_inst[11]) ||
             (use_rs1 && h_inst[19]) ||
             (use_rs2 && h_inst[24])) begin
            illegal = 1'b1;
         end
      end
      exc_d[EXC_ILLEGAL] = illegal;
   end

   // output bundle: load on pop, clear on consume, hold while stalled
   always_ff @(posedge i_clk or negedge i_rst_n) begin : bundle_reg
      if (!i_rst_n) begin
         o_valid     <= 1'b0;
         o_pc        <= '0;
         o_rs1_addr  <= '0;
         o_rs2_addr  <= '0;
         o_rd_addr   <= '0;
         o_funct3    <= '0;
         o_imm       <= '0;
         o_alu       <= '0;
         o_muldiv    <= '0;
         o_opcode    <= '0;
         o_exception <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (pop) begin
         o_valid     <= 1'b1;
         o_pc        <= h_pc;
         o_rs1_addr  <= h_inst[19:15];
         o_rs2_addr  <= h_inst[24:20];
         o_rd_addr   <= h_inst[11:7];
         o_funct3    <= h_f3;
         o_imm       <= imm_d;
         o_alu       <= alu_d;
         o_muldiv    <= md_d;
         o_opcode    <= opc_d;
         o_exception <= exc_d;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32_decoder_queue.sv
// Directed bench for rv32_decoder_queue: three instances (default, EN_M=0,
// RV32E) share stimulus; expected bundles are queued on push and checked
// whenever a bundle is presented.
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module tb_rv32_decoder_queue;

   localparam int unsigned AW = `ALU_WIDTH;
   localparam int unsigned OW = `OPCODE_WIDTH;
   localparam int unsigned XW = `EXCEPTION_WIDTH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic        i_flush = 1'b0;
   logic [31:0] i_inst = '0;
   logic [31:0] i_pc = '0;

   logic          o_ready, o_valid;
   logic [31:0]   o_pc, o_imm;
   logic [4:0]    o_rs1, o_rs2, o_rd;
   logic [2:0]    o_f3;
   logic [AW-1:0] o_alu;
   logic [7:0]    o_md;
   logic [OW-1:0] o_opc;
   logic [XW-1:0] o_exc;
   logic [1:0]    o_count;

   logic          n_ready, n_valid;
   logic [31:0]   n_pc, n_imm;
   logic [4:0]    n_rs1, n_rs2, n_rd;
   logic [2:0]    n_f3;
   logic [AW-1:0] n_alu;
   logic [7:0]    n_md;
   logic [OW-1:0] n_opc;
   logic [XW-1:0] n_exc;
   logic [1:0]    n_count;

   logic          e_ready, e_valid;
   logic [31:0]   e_pc, e_imm;
   logic [4:0]    e_rs1, e_rs2, e_rd;
   logic [2:0]    e_f3;
   logic [AW-1:0] e_alu;
   logic [7:0]    e_md;
   logic [OW-1:0] e_opc;
   logic [XW-1:0] e_exc;
   logic [1:0]    e_count;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0]   pc;
      logic [31:0]   inst;
      logic [31:0]   imm;
      logic [AW-1:0] alu;
      logic [7:0]    md;
      logic [OW-1:0] opc;
      logic [XW-1:0] exc;
      logic [XW-1:0] exc_n;
      logic [XW-1:0] exc_e;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   rv32_decoder_queue #(.DEPTH(2), .EN_M(1), .NUM_REGS(32)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_inst(i_inst), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
      .o_pc(o_pc), .o_rs1_addr(o_rs1), .o_rs2_addr(o_rs2), .o_rd_addr(o_rd),
      .o_funct3(o_f3), .o_imm(o_imm), .o_alu(o_alu), .o_muldiv(o_md),
      .o_opcode(o_opc), .o_exception(o_exc), .i_flush(i_flush), .o_count(o_count));

   rv32_decoder_queue #(.DEPTH(2), .EN_M(0), .NUM_REGS(32)) u_dut_nom (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(n_ready),
      .i_inst(i_inst), .i_pc(i_pc), .o_valid(n_valid), .i_ready(i_ready),
      .o_pc(n_pc), .o_rs1_addr(n_rs1), .o_rs2_addr(n_rs2), .o_rd_addr(n_rd),
      .o_funct3(n_f3), .o_imm(n_imm), .o_alu(n_alu), .o_muldiv(n_md),
      .o_opcode(n_opc), .o_exception(n_exc), .i_flush(i_flush), .o_count(n_count));

   rv32_decoder_queue #(.DEPTH(2), .EN_M(1), .NUM_REGS(16)) u_dut_e (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(e_ready),
      .i_inst(i_inst), .i_pc(i_pc), .o_valid(e_valid), .i_ready(i_ready),
      .o_pc(e_pc), .o_rs1_addr(e_rs1), .o_rs2_addr(e_rs2), .o_rd_addr(e_rd),
      .o_funct3(e_f3), .o_imm(e_imm), .o_alu(e_alu), .o_muldiv(e_md),
      .o_opcode(e_opc), .o_exception(e_exc), .i_flush(i_flush), .o_count(e_count));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one instruction, wait (bounded) for ready, queue its expected bundle
   task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] imm, input logic [AW-1:0] alu,
                       input logic [7:0] md, input logic [OW-1:0] opc,
                       input logic [XW-1:0] x0, input logic [XW-1:0] xn,
                       input logic [XW-1:0] xe);
      exp_t e;
      int   waited;
      waited = 0;
      while (!o_ready && waited < 50) begin
         tick();
         waited++;
      end
      chk("push_ready", 64'(o_ready), 64'(1));
      i_valid = 1'b1;
      i_inst  = inst;
      i_pc    = pc;
      e.pc = pc; e.inst = inst; e.imm = imm; e.alu = alu; e.md = md;
      e.opc = opc; e.exc = x0; e.exc_n = xn; e.exc_e = xe;
      sb.push_back(e);
      tick();
      i_valid = 1'b0;
   endtask

   // scoreboard check of every presented bundle, mid-cycle
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && o_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_bundle", 64'(o_valid), 64'(0));
         end else begin
            e = sb[0];
            chk("pc", 64'(o_pc), 64'(e.pc));
            chk("fields", 64'({o_rs1, o_rs2, o_rd, o_f3}),
                64'({e.inst[19:15], e.inst[24:20], e.inst[11:7], e.inst[14:12]}));
            chk("imm", 64'(o_imm), 64'(e.imm));
            chk("alu", 64'(o_alu), 64'(e.alu));
            chk("muldiv", 64'(o_md), 64'(e.md));
            chk("opcode", 64'(o_opc), 64'(e.opc));
            chk("exc", 64'(o_exc), 64'(e.exc));
            chk("exc_nom", 64'({n_valid, n_exc}), 64'({1'b1, e.exc_n}));
            chk("exc_rv32e", 64'({e_valid, e_exc}), 64'({1'b1, e.exc_e}));
            if (i_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      // reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_ready", 64'(o_ready), 64'(1));
      chk("rst_count", 64'(o_count), 64'(0));
      chk("rst_bundle", 64'({o_pc, o_imm}), 64'(0));
      chk("rst_alu_exc", 64'({o_alu, o_exc, o_opc, o_md}), 64'(0));
      rst_n = 1'b1;
      tick();

      // first-instruction latency with i_ready high
      i_ready = 1'b1;
      push(32'h100, 32'hFFB10093, 32'hFFFFFFFB, 14'h0001, 8'h00, 11'h002, 4'h0, 4'h0, 4'h0);
      chk("lat_edge_n_valid", 64'(o_valid), 64'(0));
      chk("lat_edge_n_count", 64'(o_count), 64'(1));
      tick();
      chk("lat_edge_n1_valid", 64'(o_valid), 64'(1));
      chk("addi_imm", 64'(o_imm), 64'(32'hFFFFFFFB));
      chk("addi_rd_pc", 64'({o_rd, o_pc}), 64'({5'd1, 32'h100}));
      tick();
      tick();
      chk("consumed_valid", 64'(o_valid), 64'(0));

      // back-pressure: two queued plus one held
      i_ready = 1'b0;
      push(32'h200, 32'h022081B3, 32'h0, 14'h0000, 8'h01, 11'h001, 4'h0, 4'h1, 4'h0);
      push(32'h204, 32'h002088B3, 32'h0, 14'h0001, 8'h00, 11'h001, 4'h0, 4'h0, 4'h1);
      push(32'h208, 32'h02009093, 32'h20, 14'h0080, 8'h00, 11'h002, 4'h1, 4'h1, 4'h1);
      chk("full_ready", 64'(o_ready), 64'(0));
      chk("full_count", 64'(o_count), 64'(2));
      chk("full_valid", 64'(o_valid), 64'(1));
      i_valid = 1'b1;
      i_inst  = 32'h00000013;
      i_pc    = 32'h20C;
      tick();
      i_valid = 1'b0;
      chk("full_no_push", 64'(o_count), 64'(2));
      tick();
      tick();
      i_ready = 1'b1;
      tick();
      chk("drain1", 64'({o_valid, o_count}), 64'({1'b1, 2'd1}));
      tick();
      chk("drain2", 64'({o_valid, o_count}), 64'({1'b1, 2'd0}));
      tick();
      chk("drain3", 64'(o_valid), 64'(0));
      chk("drain_sb_empty", 64'(sb.size()), 64'(0));

      // streaming decode coverage at full rate
      push(32'h300, 32'h00000073, 32'h0, 14'h0001, 8'h00, 11'h200, 4'h2, 4'h2, 4'h2);
      push(32'h304, 32'h407302B3, 32'h0, 14'h0002, 8'h00, 11'h001, 4'h0, 4'h0, 4'h0);
      push(32'h308, 32'h00209463, 32'h8, 14'h0800, 8'h00, 11'h010, 4'h0, 4'h0, 4'h0);
      push(32'h30C, 32'h12345537, 32'h12345000, 14'h0001, 8'h00, 11'h080, 4'h0, 4'h0, 4'h0);
      push(32'h310, 32'hFFFFFFFF, 32'h0, 14'h0001, 8'h00, 11'h000, 4'h1, 4'h1, 4'h1);
      push(32'h314, 32'h0220D1B3, 32'h0, 14'h0000, 8'h20, 11'h001, 4'h0, 4'h1, 4'h0);
      push(32'h318, 32'h402091B3, 32'h0, 14'h0080, 8'h00, 11'h001, 4'h1, 4'h1, 4'h1);
      push(32'h31C, 32'h010000EF, 32'h10, 14'h0001, 8'h00, 11'h020, 4'h0, 4'h0, 4'h0);
      chk("stream_ready", 64'(o_ready), 64'(1));
      tick();
      tick();
      tick();
      chk("stream_sb_empty", 64'(sb.size()), 64'(0));

      // flush with a simultaneous push
      i_ready = 1'b0;
      push(32'h400, 32'hFFB10093, 32'hFFFFFFFB, 14'h0001, 8'h00, 11'h002, 4'h0, 4'h0, 4'h0);
      push(32'h404, 32'h407302B3, 32'h0, 14'h0002, 8'h00, 11'h001, 4'h0, 4'h0, 4'h0);
      push(32'h408, 32'h00000073, 32'h0, 14'h0001, 8'h00, 11'h200, 4'h2, 4'h2, 4'h2);
      chk("pre_flush_count", 64'(o_count), 64'(2));
      i_flush = 1'b1;
      i_valid = 1'b1;
      i_inst  = 32'h12345537;
      i_pc    = 32'h40C;
      tick();
      sb.delete();
      i_flush = 1'b0;
      i_valid = 1'b0;
      chk("flush_count", 64'(o_count), 64'(0));
      chk("flush_valid", 64'(o_valid), 64'(0));
      chk("flush_ready", 64'(o_ready), 64'(1));
      i_ready = 1'b1;
      tick();
      tick();
      chk("flush_push_lost", 64'({o_valid, o_count}), 64'(0));

      // asynchronous reset mid-stream
      i_ready = 1'b0;
      push(32'h500, 32'h00209463, 32'h8, 14'h0800, 8'h00, 11'h010, 4'h0, 4'h0, 4'h0);
      push(32'h504, 32'h0220D1B3, 32'h0, 14'h0000, 8'h20, 11'h001, 4'h0, 4'h1, 4'h0);
      chk("pre_rst_valid", 64'(o_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_valid_count", 64'({o_valid, o_count}), 64'(0));
      chk("async_rst_bundle", 64'({o_pc, o_imm}), 64'(0));
      chk("async_rst_misc", 64'({o_alu, o_md, o_opc, o_exc, o_rd}), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 64'(o_ready), 64'(1));
      i_ready = 1'b1;
      push(32'h600, 32'h00000073, 32'h0, 14'h0001, 8'h00, 11'h200, 4'h2, 4'h2, 4'h2);
      tick();
      chk("post_rst_valid", 64'(o_valid), 64'(1));
      tick();
      tick();
      chk("final_sb_empty", 64'(sb.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rv32_decoder_queue.md
Name: rv32_decoder_queue

Overview:
Next-generation decode stage: a parametrised fetch queue followed by a registered RV32 decoder.
- Replaces ce/stall chaining with valid/ready handshakes on both sides.
- Adds optional M-extension decode, optional RV32E register-range checking, and strict funct7 legality checks.
- Sits between the fetch stage (upstream) and the ALU stage (downstream).

Parameters:
DEPTH, 2, fetch queue entries; power of two, minimum 2
EN_M, 1, 1 = decode MUL/DIV group; 0 = treat funct7=0000001 R-type as illegal
NUM_REGS, 32, 32 or 16; 16 = RV32E, so any used register field >= 16 is illegal

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  fetch presents an instruction
o_ready  out  1  queue can accept; equals !full
i_inst  in  32  instruction word
i_pc  in  32  PC of i_inst
o_valid  out  1  decoded bundle valid
i_ready  in  1  downstream accepts bundle
o_pc  out  32  PC of decoded instruction
o_rs1_addr, o_rs2_addr, o_rd_addr  out  5 each  register fields inst[19:15], [24:20], [11:7]
o_funct3  out  3  inst[14:12]
o_imm  out  32  extended immediate
o_alu  out  `ALU_WIDTH  one-hot ALU op
o_muldiv  out  8  one-hot MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU, indexed by funct3
o_opcode  out  `OPCODE_WIDTH  one-hot opcode class
o_exception  out  `EXCEPTION_WIDTH  ILLEGAL/ECALL/EBREAK/MRET
i_flush  in  1  discard queue and output register
o_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
Reset:
- Reset is asynchronous and active-low on i_rst_n; the block is clocked on i_clk.
- During reset: queue empty, o_count=0, o_valid=0, o_ready=1.
- All bundle outputs reset to 0.

Queue:
- Circular buffer of {pc, inst}.
- Push when i_valid && o_ready. Pop when queue non-empty && (!o_valid || i_ready).
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves o_count unchanged.
- When full, o_ready=0, even if a pop occurs in the same cycle (no combinational ready path).

Output register:
- On pop, decode the head entry and load the full bundle; o_valid=1 on the next edge.
- When o_valid && i_ready and no pop, o_valid clears to 0.
- While o_valid && !i_ready, the bundle is held stable. Verified bit-exact.
- Latency from empty: instruction accepted at edge N, bundle valid after edge N+1.
- Throughput: 1 per cycle when i_ready is held high.

Flush:
- i_flush at edge: queue emptied, o_valid=0, o_count=0.
- A push in the same cycle is dropped. Flush wins over every other event.

ALU decode (o_alu):
- R/I-type:
  - funct3 selects ADD/SLT/SLTU/XOR/OR/AND/SLL/SRL-SRA.
  - R-type ADD vs SUB and SRL vs SRA are selected by inst[30].
  - I-type funct3=000 is always ADD.
- BRANCH: EQ/NEQ/SLT/GE/SLTU/GEU.
- Any other opcode: ADD.
- R-type with funct7=0000001 and EN_M=1: o_alu all zero and o_muldiv one-hot by funct3. Otherwise o_muldiv=0.

Immediate (o_imm):
- I/LOAD/JALR: sign-extended inst[31:20].
- STORE: S-format.
- BRANCH: B-format, LSB=0.
- JAL: J-format, LSB=0.
- LUI/AUIPC: {inst[31:12], 12'h0}.
- SYSTEM/FENCE: zero-extended inst[31:20].
- Others: 0.

Exceptions:
- ILLEGAL is set for any of:
  - unknown opcode
  - I-type shift with inst[25]=1
  - R-type funct7 not in {0000000, 0100000, 0000001}
  - funct7=0100000 with funct3 other than 000 or 101
  - funct7=0000001 with EN_M=0
  - NUM_REGS=16 and bit 4 of any register field the format uses (rd for R/I/LOAD/JAL/JALR/LUI/AUIPC; rs1 for R/I/LOAD/STORE/BRANCH/JALR; rs2 for R/STORE/BRANCH)
- SYSTEM with funct3=0: inst[21:20] = 00 gives ECALL, 01 gives EBREAK, 10 gives MRET.
- Exception bits are mutually exclusive with each other except where ILLEGAL co-occurs.

Test Plan:
- Reset, then push ADDI x1,x2,-5 (0xFFB10093) with PC=0x100 and i_ready=1 -> o_valid one cycle after the accept edge; o_imm=0xFFFFFFFB, o_alu[ADD]=1, o_rd_addr=1, o_pc=0x100.
- DEPTH=2, i_ready=0, push 3 instructions -> o_ready=0 after 2 queued plus 1 held; o_count=2; bundle stable; then i_ready=1 -> all three emerge in order at 1 per cycle.
- Push MUL x3,x1,x2 (0x022081B3): EN_M=1 -> o_muldiv=8'b00000001, o_alu=0, ILLEGAL=0; EN_M=0 -> ILLEGAL=1.
- NUM_REGS=16, push ADD x17,x1,x2 (0x002088B3) -> ILLEGAL=1; SLLI with inst[25]=1 -> ILLEGAL=1; ECALL 0x00000073 -> ECALL=1.
- Queue holding 2, i_flush asserted together with i_valid -> next cycle o_count=0, o_valid=0, pushed instruction lost.
- Assert i_rst_n low mid-stream while the queue is non-empty -> all outputs 0 immediately, without waiting for a clock edge.
